// File: rtl/arb_pkg.sv
// Shared definitions for the 16-way round-robin request arbiter.
package arb_pkg;

  localparam int NUM_REQ            = 16;
  localparam int IDX_W              = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/Decoder4x16.sv
// Binary-to-one-hot decoder used to build per-requester enables.
module Decoder4x16 (
  input  logic [3:0]  idx,
  output logic [15:0] oh
);

  // One bit set at the position named by idx
  always_comb begin
    oh = 16'h0001 << idx;
  end

endmodule

// File: rtl/req_arbiter_rr16.sv
// Round-robin arbiter, 16 requesters, grant held until done or withdrawal.
// Define ARB_TIMEOUT_EN to build the hold watchdog (limit TIMEOUT_CYCLES).
module req_arbiter_rr16
  import arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic                done,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_idx,
  output logic [NUM_REQ-1:0]  grant_oh,
  output logic                timeout
);

  arb_state_e          state_r, state_nxt_s;
  logic [IDX_W-1:0]    ptr_r, ptr_nxt_s;
  logic [IDX_W-1:0]    grant_idx_r, grant_idx_nxt_s;
  logic                grant_valid_r, grant_valid_nxt_s;
  logic                timeout_r, timeout_nxt_s;
  logic [IDX_W:0]      pick_s;
  logic                release_s;
  logic [NUM_REQ-1:0]  dec_oh_s;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] hold_cnt_r, hold_cnt_nxt_s;
`endif

  // First set bit scanning ptr, ptr+1, ... wrapping; MSB flags a hit.
  // Scanning downwards lets the smallest offset overwrite the result last.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] j;
    res = {1'b0, 4'd0};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = p + IDX_W'(i);
      if (r[j]) begin
        res = {1'b1, j};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s    = rr_pick(req, ptr_r);
  assign release_s = done | ~req[grant_idx_r];

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s       = state_r;
    ptr_nxt_s         = ptr_r;
    grant_idx_nxt_s   = grant_idx_r;
    grant_valid_nxt_s = grant_valid_r;
    timeout_nxt_s     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_nxt_s    = hold_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (pick_s[IDX_W]) begin
          grant_idx_nxt_s   = pick_s[IDX_W-1:0];
          grant_valid_nxt_s = 1'b1;
          state_nxt_s       = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_nxt_s    = 16'd0;
`endif
        end else begin
          grant_valid_nxt_s = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          grant_valid_nxt_s = 1'b0;
          ptr_nxt_s         = grant_idx_r + 4'd1;
          state_nxt_s       = IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_cnt_r == HOLD_LAST) begin
          grant_valid_nxt_s = 1'b0;
          ptr_nxt_s         = grant_idx_r + 4'd1;
          timeout_nxt_s     = 1'b1;
          state_nxt_s       = IDLE;
        end else begin
          hold_cnt_nxt_s    = hold_cnt_r + 16'd1;
        end
`else
        end else begin
          grant_valid_nxt_s = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt_s       = IDLE;
        grant_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      ptr_r         <= 4'd0;
      grant_idx_r   <= 4'd0;
      grant_valid_r <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      ptr_r         <= ptr_nxt_s;
      grant_idx_r   <= grant_idx_nxt_s;
      grant_valid_r <= grant_valid_nxt_s;
      timeout_r     <= timeout_nxt_s;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Grant hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= 16'd0;
    end else begin
      hold_cnt_r <= hold_cnt_nxt_s;
    end
  end
`endif

  Decoder4x16 u_dec (
    .idx (grant_idx_r),
    .oh  (dec_oh_s)
  );

  assign grant_valid = grant_valid_r;
  assign grant_idx   = grant_idx_r;
  assign grant_oh    = dec_oh_s & {NUM_REQ{grant_valid_r}};
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_req_arbiter_rr16.sv
// Scoreboard bench for req_arbiter_rr16: reference model pushes expectations,
// monitor pops and compares after every clock edge.
module tb_req_arbiter_rr16;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = 16'h0000;
  logic        done = 1'b0;
  logic        grant_valid;
  logic [3:0]  grant_idx;
  logic [15:0] grant_oh;
  logic        timeout;

  req_arbiter_rr16 #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_oh    (grant_oh),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  idx;
    logic [15:0] oh;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state: owner -1 means nobody holds the resource
  int m_owner = -1;
  int m_ptr   = 0;
  int m_last  = 0;
  int m_hold  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference model: applies the arbitration rules to the inputs seen at each edge
  always @(posedge clk) begin
    exp_t e;
    bit   to_now;
    to_now = 1'b0;
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_last  = 0;
      m_hold  = 0;
    end else begin
      if (m_owner < 0) begin
        for (int k = 0; k < 16; k++) begin
          int j;
          j = (m_ptr + k) % 16;
          if (req[j]) begin
            m_owner = j;
            m_last  = j;
            m_hold  = 0;
            break;
          end
        end
      end else if (done || !req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_hold + 1 == TB_TO) begin
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
        to_now  = 1'b1;
      end else begin
        m_hold++;
      end
`endif
      e.v   = (m_owner >= 0);
      e.idx = m_last[3:0];
      e.oh  = (m_owner >= 0) ? (16'h0001 << m_last) : 16'h0000;
      e.to  = to_now;
      exp_q.push_back(e);
    end
  end

  // Monitor: compares DUT outputs with the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_valid",   {31'd0, grant_valid}, {31'd0, e.v});
      check("sb_idx",     {28'd0, grant_idx},   {28'd0, e.idx});
      check("sb_oh",      {16'd0, grant_oh},    {16'd0, e.oh});
      check("sb_timeout", {31'd0, timeout},     {31'd0, e.to});
    end
  end

  task automatic wait_grant(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (grant_valid) break;
    end
    check(name, {31'd0, grant_valid}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 16'h0000;
    done  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   got[$];
    logic prev;
    #1;
    check("rst_valid", {31'd0, grant_valid}, 32'd0);
    check("rst_idx",   {28'd0, grant_idx},   32'd0);
    check("rst_oh",    {16'd0, grant_oh},    32'd0);
    check("rst_to",    {31'd0, timeout},     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single requester 3
    @(negedge clk);
    req = 16'h0008;
    @(negedge clk);
    check("single_valid", {31'd0, grant_valid}, 32'd1);
    check("single_idx",   {28'd0, grant_idx},   32'd3);
    check("single_oh",    {16'd0, grant_oh},    32'h0008);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 16'h0000;
    check("single_release", {31'd0, grant_valid}, 32'd0);

    // round robin over all requesters, done every third cycle
    do_reset();
    req  = 16'hFFFF;
    prev = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (grant_valid && !prev) got.push_back(int'(grant_idx));
      prev = grant_valid;
      done = (c % 3 == 2);
    end
    done = 1'b0;
    req  = 16'h0000;
    for (int i = 0; i < 17; i++) begin
      check("rr_seq", (got.size() > i) ? got[i] : 32'hFF, i % 16);
    end

    // wrap and skip: grant 13 leaves ptr at 14
    do_reset();
    req = 16'h2000;
    wait_grant("wrap_wait13");
    check("wrap_idx13", {28'd0, grant_idx}, 32'd13);
    done = 1'b1;
    req  = 16'h0011;
    @(negedge clk);
    done = 1'b0;
    wait_grant("wrap_wait0");
    check("wrap_idx0", {28'd0, grant_idx}, 32'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_grant("wrap_wait4");
    check("wrap_idx4", {28'd0, grant_idx}, 32'd4);
    done = 1'b1;
    req  = 16'h0000;
    @(negedge clk);
    done = 1'b0;

    // withdrawal of requester 7 moves ptr to 8
    req = 16'h0080;
    wait_grant("wd_wait7");
    check("wd_idx7", {28'd0, grant_idx}, 32'd7);
    req = 16'h0000;
    @(negedge clk);
    check("wd_release", {31'd0, grant_valid}, 32'd0);
    req = 16'hFFFF;
    wait_grant("wd_wait8");
    check("wd_ptr8", {28'd0, grant_idx}, 32'd8);
    req = 16'h0000;
    repeat (2) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    // watchdog revokes requester 2, requester 3 is next
    do_reset();
    req = 16'h000C;
    wait_grant("to_wait2");
    check("to_idx2", {28'd0, grant_idx}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (timeout) break;
    end
    check("to_pulse", {31'd0, timeout}, 32'd1);
    check("to_revoked", {31'd0, grant_valid}, 32'd0);
    wait_grant("to_wait3");
    check("to_idx3", {28'd0, grant_idx}, 32'd3);
    req = 16'h0000;
    repeat (2) @(negedge clk);
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0: req = 16'h0000;
        1: req = 16'h0001 << $urandom_range(0, 15);
        2: req = 16'($urandom);
        default: req = req;
      endcase
      done = ($urandom_range(0, 3) == 0);
    end
    req  = 16'h0000;
    done = 1'b0;
    repeat (3) @(negedge clk);

    // asynchronous reset in the middle of a grant to requester 5
    req = 16'h0020;
    wait_grant("mr_wait5");
    check("mr_idx5", {28'd0, grant_idx}, 32'd5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mr_valid", {31'd0, grant_valid}, 32'd0);
    check("mr_idx",   {28'd0, grant_idx},   32'd0);
    check("mr_oh",    {16'd0, grant_oh},    32'd0);
    check("mr_to",    {31'd0, timeout},     32'd0);
    req = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mr_stay_idle", {31'd0, grant_valid}, 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
